pwm_tick_gen: RTL and testbench

Downstream consumer of the clock divider's slow output. Synchronizes the divided clock level into the `clk` domain and edge-detects it into single-cycle `tick` strobes. Those ticks drive a programmable PWM whose period and duty are in tick units. Period and duty sit in double-buffered configuration registers that update only at period boundaries, so the waveform never glitches mid-period.

---
 rtl/pwm_tick_gen.sv | 122 ++++++++++++
 tb/tb_pwm_tick_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - synchronized tick generator driving a double-buffered PWM
module pwm_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             tick,
  output logic             pwm_out,
  output logic             period_done,
  output logic             cfg_ack,
  output logic             running
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   edge_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       period_s, duty_s;
  logic [CNT_W-1:0]       period_a, duty_a;
  logic                   load_pending;

  logic                   tick_c, wrap_c, xfer_c;
  logic [CNT_W-1:0]       period_n, duty_n;

  // vld_q marks when edge_q holds a real sample, so a level already high at
  // reset release never produces a tick without a fresh 0->1.
  always_comb begin
    tick_c   = sync_q[SYNC_STAGES-1] & ~edge_q & vld_q[SYNC_STAGES];
    wrap_c   = (state != IDLE) && tick_c &&
               ((period_a == '0) || (cnt == period_a - CNT_W'(1)));
    xfer_c   = (state == IDLE) ? load_pending : (wrap_c && (load_pending || load));
    period_n = load ? period : period_s;
    duty_n   = load ? duty   : duty_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      edge_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      edge_q <= sync_q[SYNC_STAGES-1];
      tick   <= tick_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period_s     <= '0;
      duty_s       <= '0;
      period_a     <= '0;
      duty_a       <= '0;
      load_pending <= 1'b0;
      pwm_out      <= 1'b0;
      period_done  <= 1'b0;
      cfg_ack      <= 1'b0;
      running      <= 1'b0;
    end else begin
      period_done <= 1'b0;
      cfg_ack     <= 1'b0;
      pwm_out     <= (state != IDLE) && (period_a != '0) && (cnt < duty_a);

      if (load) begin
        period_s     <= period;
        duty_s       <= duty;
        load_pending <= 1'b1;
      end
      // A coincident load is forwarded straight into the active config.
      if (xfer_c) begin
        period_a     <= period_n;
        duty_a       <= duty_n;
        load_pending <= 1'b0;
        cfg_ack      <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          running <= en;
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          if (tick_c) begin
            if (wrap_c) begin
              cnt         <= '0;
              period_done <= (period_a != '0);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          if (state == RUN) begin
            running <= 1'b1;
            if (!en) state <= STOP;
          end else begin
            running <= en || !wrap_c;
            if (en)          state <= RUN;
            else if (wrap_c) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// tb/tb_pwm_tick_gen.sv - directed and randomized bench for pwm_tick_gen against a tick-level model
module tb_pwm_tick_gen;
  localparam int W = 16;

  logic         clk = 1'b0, reset = 1'b1, slow_clk_in = 1'b0, en = 1'b0, load = 1'b0;
  logic [W-1:0] period = '0, duty = '0;
  logic         tick, pwm_out, period_done, cfg_ack, running;

  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  pwm_tick_gen #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in), .en(en), .load(load),
    .period(period), .duty(duty), .tick(tick), .pwm_out(pwm_out),
    .period_done(period_done), .cfg_ack(cfg_ack), .running(running)
  );

  // slow clock generator
  bit auto_slow = 0, rand_half = 0;
  int half = 4, ph = 0;
  // reference model: sample history, mode (0 idle, 1 run, 2 stop), tick position in period
  bit h1, h2, h3;
  int n_since, mode, pos, pa, da, ps, ds, tick_cnt;
  bit pend, e_tick, e_done, e_ack, e_pwm, e_run;

  task automatic chk(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    {h1, h2, h3, pend} = '0;
    {e_tick, e_done, e_ack, e_pwm, e_run} = '0;
    n_since = 0; mode = 0; pos = 0; pa = 0; da = 0; ps = 0; ds = 0;
  endtask

  // Predicts the outputs visible after the coming clock edge from the current inputs.
  task automatic model_edge();
    bit tk, wrap, xfer;
    int np, nd;
    tk   = (n_since >= 3) && h2 && !h3;
    wrap = (mode != 0) && tk && (pa == 0 || pos == pa - 1);
    xfer = (mode == 0) ? pend : (wrap && (pend || load));
    np   = load ? int'(period) : ps;
    nd   = load ? int'(duty) : ds;
    e_tick = tk;
    e_done = wrap && (pa != 0);
    e_ack  = xfer;
    e_pwm  = (mode != 0) && (pa != 0) && (pos < da);
    if (load) begin ps = int'(period); ds = int'(duty); pend = 1; end
    if (mode == 0)  pos = 0;
    else if (tk)    pos = wrap ? 0 : pos + 1;
    case (mode)
      0: if (en) mode = 1;
      1: if (!en) mode = 2;
      default: if (en) mode = 1; else if (wrap) mode = 0;
    endcase
    e_run = (mode != 0);
    if (xfer) begin pa = np; da = nd; pend = 0; end
    h3 = h2; h2 = h1; h1 = slow_clk_in;
    n_since++;
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      if (auto_slow) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          slow_clk_in = ~slow_clk_in;
          if (rand_half) half = $urandom_range(3, 6);
        end
      end
      model_edge();
      @(posedge clk);
      @(negedge clk);
      if (tick) tick_cnt++;
      chk("tick", tick, e_tick);
      chk("period_done", period_done, e_done);
      chk("cfg_ack", cfg_ack, e_ack);
      chk("pwm_out", pwm_out, e_pwm);
      chk("running", running, e_run);
    end
  endtask

  task automatic step_until(int p, int md);
    int k = 0;
    while (!(pos == p && mode == md) && k < 300) begin step(1); k++; end
    chk("until_bound", logic'(k < 300), 1'b1);
  endtask

  task automatic do_load(int p, int d);
    period = W'(p); duty = W'(d); load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_pwm"}, pwm_out, 1'b0);
    chk({tag, "_done"}, period_done, 1'b0);
    chk({tag, "_ack"}, cfg_ack, 1'b0);
    chk({tag, "_run"}, running, 1'b0);
  endtask

  initial begin
    model_clear();
    #1 reset = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // divide-by-8 slow clock: exactly one tick per rising edge
    auto_slow = 1; half = 4; ph = 0; tick_cnt = 0;
    step(64);
    chk_int("tick_count_div8", tick_cnt, 8);

    // basic PWM 5/2 with cfg_ack one cycle after load in IDLE
    do_load(5, 2);
    step(1);
    en = 1'b1;
    step(100);

    // reconfigure mid-period; takes effect at the next wrap
    step_until(2, 1);
    do_load(4, 3);
    step(80);

    // duty and period extremes
    do_load(5, 0);  step(90);
    do_load(5, 7);  step(90);
    do_load(0, 3);  step(60);

    // stop behaviour
    do_load(5, 2);
    step_until(0, 1);
    step_until(2, 1);
    en = 1'b0;
    step_until(0, 0);
    step(5);
    en = 1'b1;
    step_until(2, 1);
    en = 1'b0;
    step_until(3, 2);
    en = 1'b1;
    step(60);

    // asynchronous reset mid-run, then released with slow_clk_in held high
    step_until(2, 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    auto_slow = 0; slow_clk_in = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    tick_cnt = 0;
    step(12);
    chk_int("no_tick_held_high", tick_cnt, 0);
    slow_clk_in = 1'b0; step(5);
    slow_clk_in = 1'b1; step(6);
    chk_int("tick_after_fresh_rise", tick_cnt, 1);

    // randomized enables, loads and slow clock half periods
    auto_slow = 1; rand_half = 1; ph = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) begin
        period = W'($urandom_range(0, 7));
        duty   = W'($urandom_range(0, 9));
        load   = 1'b1;
      end
      step(1);
      load = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
